// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, word geometry and the address-legality helper live here.
package mem_responder_pkg;

  localparam int NUM_LANES = 4;
  localparam int WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A word access is legal only when aligned and inside the array.
  function automatic logic addr_is_bad(input logic [WORD_W-1:0] addr, input int depth_log2);
    logic [WORD_W-1:0] upper;
    upper = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU load/store port and the responder.
// The CPU side uses the master modport, the memory side uses the slave modport.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [NUM_LANES-1:0] req_be;
  logic [WORD_W-1:0]    req_addr;
  logic [WORD_W-1:0]    req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_W-1:0]    rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word array with per-byte write enables, synchronous clear and combinational read.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int lane = 0; lane < NUM_LANES; lane++) begin
        if (be[lane]) begin
          mem_d[idx][8*lane +: 8] = wdata[8*lane +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, then
// performs the access and holds the response until the CPU takes it.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [NUM_LANES-1:0] be_q, be_d;
  logic [WORD_W-1:0]    addr_q, addr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic [WORD_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 in_idle;
  logic                 enter_resp;
  logic                 acc_we;
  logic [NUM_LANES-1:0] acc_be;
  logic [WORD_W-1:0]    acc_addr;
  logic [WORD_W-1:0]    acc_wdata;
  logic                 acc_err;
  logic                 arr_we;
  logic [WORD_W-1:0]    arr_rdata;

  assign in_idle = (state_q == IDLE);

  // With zero latency the access happens on the accept edge, so it must use
  // the live request rather than the latched copy.
  assign acc_we    = in_idle ? bus.req_we    : we_q;
  assign acc_be    = in_idle ? bus.req_be    : be_q;
  assign acc_addr  = in_idle ? bus.req_addr  : addr_q;
  assign acc_wdata = in_idle ? bus.req_wdata : wdata_q;
  assign acc_err   = addr_is_bad(acc_addr, DEPTH_LOG2);

  assign enter_resp = (in_idle && bus.req_valid && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
  assign arr_we     = enter_resp && acc_we && !acc_err;

  mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .be    (acc_be),
    .idx   (acc_addr[DEPTH_LOG2+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          be_d    = bus.req_be;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY != 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d = RESP;
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? '0 : arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// compared against a plain word-array model; a second instance covers LATENCY=0.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_responder_if bus ();
  mem_responder_if bus0 ();

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  logic [31:0] model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the LATENCY=LAT instance, starting and ending at a negedge.
  task automatic apply_stimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold, input string tag);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          idx;
    int          n;
    exp_err   = (addr % 4 != 0) || (addr >= DEPTH * 4);
    idx       = int'(addr / 4) % DEPTH;
    exp_rdata = (!we && !exp_err) ? model[idx] : 32'h0;
    if (we && !exp_err) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) model[idx][8*l +: 8] = wdata[8*l +: 8];
      end
    end

    check_output({tag, " req_ready idle"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_be    = be;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    check_output({tag, " req_ready busy"}, {31'b0, bus.req_ready}, 32'd0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, " latency"}, n, LAT);
    check_output({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    check_output({tag, " err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_output({tag, " hold valid"}, {31'b0, bus.rsp_valid}, 32'd1);
      check_output({tag, " hold rdata"}, bus.rsp_rdata, exp_rdata);
      check_output({tag, " hold err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
      check_output({tag, " hold ready"}, {31'b0, bus.req_ready}, 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_output({tag, " post valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    check_output({tag, " post ready"}, {31'b0, bus.req_ready}, 32'd1);
    check_output({tag, " post rdata"}, bus.rsp_rdata, 32'h0);
  endtask

  initial begin
    logic        seen;
    logic        r_we;
    logic [31:0] r_addr;
    int          mode;

    foreach (model[i]) model[i] = 32'h0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_be     = 4'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_be    = 4'h0;
    bus0.req_addr  = 32'h0;
    bus0.req_wdata = 32'h0;
    bus0.rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
    check_output("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_output("reset rdata", bus.rsp_rdata, 32'h0);
    check_output("reset err", {31'b0, bus.rsp_err}, 32'd0);
    check_output("reset0 req_ready", {31'b0, bus0.req_ready}, 32'd1);
    check_output("reset0 rsp_valid", {31'b0, bus0.rsp_valid}, 32'd0);

    apply_stimulus(1'b0, 4'h0, 32'h0000_0010, 32'h0, 0, "load after reset");
    apply_stimulus(1'b1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF, 0, "store 8");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0008, 32'h0, 0, "load 8");
    apply_stimulus(1'b1, 4'hF, 32'h0000_0004, 32'h1122_3344, 0, "store 4 full");
    apply_stimulus(1'b1, 4'b0101, 32'h0000_0004, 32'hAABB_CCDD, 0, "store 4 partial");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0004, 32'h0, 0, "load 4 merged");
    check_output("model merge", model[1], 32'h11BB_33DD);
    apply_stimulus(1'b1, 4'h0, 32'h0000_0008, 32'h1234_5678, 0, "store be0");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0008, 32'h0, 0, "load after be0");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0002, 32'h0, 0, "load misaligned");
    apply_stimulus(1'b1, 4'hF, 32'h0000_0100, 32'hFFFF_FFFF, 0, "store out of range");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0000, 32'h0, 0, "load 0 unchanged");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0008, 32'h0, 5, "backpressure");

    // Reset while the store is still waiting: it must vanish without a response.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = 32'h0000_000C;
    bus.req_wdata = 32'h0000_00FF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_output("midrst in wait", {31'b0, bus.req_ready}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (model[i]) model[i] = 32'h0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check_output("midrst no response", {31'b0, seen}, 32'd0);
    apply_stimulus(1'b0, 4'h0, 32'h0000_000C, 32'h0, 0, "load C after reset");
    apply_stimulus(1'b0, 4'h0, 32'h0000_0008, 32'h0, 0, "load 8 cleared");

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 9);
      r_we = 1'($urandom_range(0, 1));
      if (mode == 0) r_addr = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (mode == 1) r_addr = {$urandom_range(1, 255), 8'($urandom)} & 32'hFFFF_FFFC;
      else r_addr = {24'h0, 6'($urandom_range(0, 7)), 2'b00};
      apply_stimulus(r_we, 4'($urandom), r_addr, $urandom, $urandom_range(0, 3), "random");
    end

    // Zero-latency instance: response is visible in the cycle after the accept edge.
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b1;
    bus0.req_be    = 4'hF;
    bus0.req_addr  = 32'h0000_0014;
    bus0.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    check_output("lat0 store valid", {31'b0, bus0.rsp_valid}, 32'd1);
    check_output("lat0 store rdata", bus0.rsp_rdata, 32'h0);
    check_output("lat0 store err", {31'b0, bus0.rsp_err}, 32'd0);
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    check_output("lat0 post valid", {31'b0, bus0.rsp_valid}, 32'd0);
    bus0.req_valid = 1'b1;
    bus0.req_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    check_output("lat0 load valid", {31'b0, bus0.rsp_valid}, 32'd1);
    check_output("lat0 load rdata", bus0.rsp_rdata, 32'hCAFE_F00D);
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    check_output("lat0 idle ready", {31'b0, bus0.req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
